// File: rtl/ruby_lsu_req_queue_if.sv
// Payload types and the LSU/L1D handshake bundle for ruby_lsu_req_queue.
// The package lives here so the interface and the queue share one definition.
package ruby_lsu_req_queue_pkg;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned ROB_W   = 7;
    localparam int unsigned PREG_W  = 7;
    localparam int unsigned PADDR_W = 56;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned TYPE_W  = 6;

    localparam logic [TYPE_W-1:0] LSU_FENCE = 6'd38;

    typedef struct packed {
        logic [ID_W-1:0]    lsu_id;
        logic [ROB_W-1:0]   rob_id;
        logic [TYPE_W-1:0]  req_type;
        logic [PADDR_W-1:0] paddr;
        logic [PREG_W-1:0]  ld_rd_idx;
        logic [XLEN-1:0]    st_dat;
        logic               is_cacheable;
        logic               is_secure;
    } lsu_req_t;

    typedef struct packed {
        logic [ID_W-1:0]    lsu_id;
        logic [ROB_W-1:0]   rob_id;
        logic [TYPE_W-1:0]  req_type;
        logic [XLEN-1:0]    ld_data;
        logic [PREG_W-1:0]  ld_rd_idx;
        logic               err;
    } lsu_resp_t;
endpackage

interface ruby_lsu_req_queue_if;
    import ruby_lsu_req_queue_pkg::*;

    logic      lsu_req_vld_i;
    logic      lsu_req_rdy_o;
    lsu_req_t  lsu_req_i;
    logic      l1d_req_vld_o;
    logic      l1d_req_rdy_i;
    lsu_req_t  l1d_req_o;
    logic      l1d_resp_vld_i;
    lsu_resp_t l1d_resp_i;
    logic      lsu_resp_vld_o;
    lsu_resp_t lsu_resp_o;

    modport slave (
        input  lsu_req_vld_i, lsu_req_i, l1d_req_rdy_i, l1d_resp_vld_i, l1d_resp_i,
        output lsu_req_rdy_o, l1d_req_vld_o, l1d_req_o, lsu_resp_vld_o, lsu_resp_o
    );

    modport master (
        output lsu_req_vld_i, lsu_req_i, l1d_req_rdy_i, l1d_resp_vld_i, l1d_resp_i,
        input  lsu_req_rdy_o, l1d_req_vld_o, l1d_req_o, lsu_resp_vld_o, lsu_resp_o
    );
endinterface

// File: rtl/ruby_lsu_req_queue.sv
// In-order LSU->L1D request queue with in-flight cap and local fence completion.
// Optional RUBY_LSU_REQ_QUEUE_BYPASS_EN: zero-latency issue when the queue is empty.
module ruby_lsu_req_queue
    import ruby_lsu_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_OUTS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ruby_lsu_req_queue_if.slave bus,
    output logic [7:0]          outs_cnt_o,
    output logic                underflow_err_o
);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam logic [7:0]  MAX_CNT = 8'(MAX_OUTS);

    lsu_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       outs_cnt_q, outs_cnt_d;
    logic             underflow_q, underflow_d;

    logic      empty, full, head_fence, can_issue, bypass;
    logic      req_vld, issue, fence_done, push, pop;
    lsu_req_t  head, req_pl;
    lsu_resp_t resp_pl;

    // Head decode, issue gating and response selection (L1D response beats local fence response).
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        head       = mem[rd_ptr_q[IDX_W-1:0]];
        head_fence = !empty && (head.req_type == LSU_FENCE);
        can_issue  = (outs_cnt_q < MAX_CNT);
`ifdef RUBY_LSU_REQ_QUEUE_BYPASS_EN
        bypass     = empty && bus.lsu_req_vld_i && (bus.lsu_req_i.req_type != LSU_FENCE) &&
                     can_issue && bus.l1d_req_rdy_i;
`else
        bypass     = 1'b0;
`endif
        req_vld    = (!empty && !head_fence && can_issue) || bypass;
        req_pl     = '0;
        if (bypass) begin
            req_pl = bus.lsu_req_i;
        end else if (req_vld) begin
            req_pl = head;
        end
        issue      = req_vld && bus.l1d_req_rdy_i;
        fence_done = head_fence && (outs_cnt_q == 8'd0) && !bus.l1d_resp_vld_i;
        push       = bus.lsu_req_vld_i && !full && !bypass;
        pop        = (issue && !bypass) || fence_done;

        resp_pl = '0;
        if (bus.l1d_resp_vld_i) begin
            resp_pl = bus.l1d_resp_i;
        end else if (fence_done) begin
            resp_pl.lsu_id    = head.lsu_id;
            resp_pl.rob_id    = head.rob_id;
            resp_pl.req_type  = head.req_type;
            resp_pl.ld_rd_idx = head.ld_rd_idx;
        end
    end

    // Next pointers, in-flight count (saturating at zero) and sticky underflow.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        outs_cnt_d  = outs_cnt_q;
        underflow_d = underflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (bus.l1d_resp_vld_i && (outs_cnt_q == 8'd0)) begin
            underflow_d = 1'b1;
        end
        if (issue && !bus.l1d_resp_vld_i) begin
            outs_cnt_d = outs_cnt_q + 8'd1;
        end else if (!issue && bus.l1d_resp_vld_i && (outs_cnt_q != 8'd0)) begin
            outs_cnt_d = outs_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            outs_cnt_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            outs_cnt_q  <= outs_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: every read of it is qualified by a non-empty queue.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= bus.lsu_req_i;
        end
    end

    assign bus.lsu_req_rdy_o  = !full;
    assign bus.l1d_req_vld_o  = req_vld;
    assign bus.l1d_req_o      = req_pl;
    assign bus.lsu_resp_vld_o = bus.l1d_resp_vld_i || fence_done;
    assign bus.lsu_resp_o     = resp_pl;
    assign outs_cnt_o         = outs_cnt_q;
    assign underflow_err_o    = underflow_q;
endmodule

// File: tb/tb_ruby_lsu_req_queue.sv
// Bench for ruby_lsu_req_queue: two instances (MAX_OUTS 8 and 2) share directed stimulus
// and are checked every cycle against a queue-based model plus hand-computed expectations.
module tb_ruby_lsu_req_queue;
    import ruby_lsu_req_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int MO0 = 8;
    localparam int MO1 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic      req_vld  = 1'b0;
    lsu_req_t  req      = '0;
    logic      l1d_rdy  = 1'b0;
    logic      resp_vld = 1'b0;
    lsu_resp_t resp     = '0;

    logic [7:0] outs0, outs1;
    logic       uf0, uf1;

    ruby_lsu_req_queue_if bus0 ();
    ruby_lsu_req_queue_if bus1 ();

    assign bus0.lsu_req_vld_i  = req_vld;
    assign bus0.lsu_req_i      = req;
    assign bus0.l1d_req_rdy_i  = l1d_rdy;
    assign bus0.l1d_resp_vld_i = resp_vld;
    assign bus0.l1d_resp_i     = resp;
    assign bus1.lsu_req_vld_i  = req_vld;
    assign bus1.lsu_req_i      = req;
    assign bus1.l1d_req_rdy_i  = l1d_rdy;
    assign bus1.l1d_resp_vld_i = resp_vld;
    assign bus1.l1d_resp_i     = resp;

    ruby_lsu_req_queue #(.DEPTH(DEPTH), .MAX_OUTS(MO0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .outs_cnt_o(outs0), .underflow_err_o(uf0));
    ruby_lsu_req_queue #(.DEPTH(DEPTH), .MAX_OUTS(MO1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .outs_cnt_o(outs1), .underflow_err_o(uf1));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: per instance, an ordered list of waiting requests, an in-flight count and a flag.
    lsu_req_t mq [2][DEPTH];
    int       mn [2];
    int       mo [2];
    bit       mu [2];

    task automatic model_cmp(input int i, input logic a_rdy, input logic a_vld, input lsu_req_t a_req,
                             input logic a_rvld, input lsu_resp_t a_resp,
                             input logic [7:0] a_outs, input logic a_uf);
        lsu_req_t  h;
        lsu_req_t  e_req;
        lsu_resp_t e_resp;
        bit hf, can, byp, e_vld, e_rdy, fdone, issue;
        int lim;
        lim = (i == 0) ? MO0 : MO1;
        if (!rst_n) begin
            mn[i] = 0;
            mo[i] = 0;
            mu[i] = 1'b0;
            chk($sformatf("d%0d_rst_vld", i),  256'(a_vld),  256'(1'b0));
            chk($sformatf("d%0d_rst_rvld", i), 256'(a_rvld), 256'(1'b0));
            chk($sformatf("d%0d_rst_rdy", i),  256'(a_rdy),  256'(1'b1));
            chk($sformatf("d%0d_rst_outs", i), 256'(a_outs), 256'(0));
            chk($sformatf("d%0d_rst_uf", i),   256'(a_uf),   256'(1'b0));
            return;
        end
        h   = (mn[i] > 0) ? mq[i][0] : '0;
        hf  = (mn[i] > 0) && (h.req_type == LSU_FENCE);
        can = (mo[i] < lim);
        byp = 1'b0;
`ifdef RUBY_LSU_REQ_QUEUE_BYPASS_EN
        byp = (mn[i] == 0) && req_vld && (req.req_type != LSU_FENCE) && can && l1d_rdy;
`endif
        e_vld = ((mn[i] > 0) && !hf && can) || byp;
        e_req = byp ? req : h;
        e_rdy = (mn[i] < int'(DEPTH));
        fdone = hf && (mo[i] == 0) && !resp_vld;
        e_resp = '0;
        if (resp_vld) begin
            e_resp = resp;
        end else begin
            e_resp.lsu_id    = h.lsu_id;
            e_resp.rob_id    = h.rob_id;
            e_resp.req_type  = h.req_type;
            e_resp.ld_rd_idx = h.ld_rd_idx;
        end

        chk($sformatf("d%0d_rdy", i),  256'(a_rdy),  256'(e_rdy));
        chk($sformatf("d%0d_vld", i),  256'(a_vld),  256'(e_vld));
        if (e_vld) chk($sformatf("d%0d_req", i), 256'(a_req), 256'(e_req));
        chk($sformatf("d%0d_rvld", i), 256'(a_rvld), 256'(resp_vld || fdone));
        if (resp_vld || fdone) chk($sformatf("d%0d_resp", i), 256'(a_resp), 256'(e_resp));
        chk($sformatf("d%0d_outs", i), 256'(a_outs), 256'(mo[i]));
        chk($sformatf("d%0d_uf", i),   256'(a_uf),   256'(mu[i]));

        issue = e_vld && l1d_rdy;
        if ((issue && !byp) || fdone) begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) mq[i][k] = mq[i][k+1];
            mn[i]--;
        end
        if (req_vld && e_rdy && !byp) begin
            mq[i][mn[i]] = req;
            mn[i]++;
        end
        if (resp_vld && mo[i] == 0) mu[i] = 1'b1;
        if (issue && !resp_vld) mo[i]++;
        else if (!issue && resp_vld && mo[i] > 0) mo[i]--;
    endtask

    // Compare just before each rising edge, then advance the model across that edge.
    always begin
        @(negedge clk);
        #4;
        model_cmp(0, bus0.lsu_req_rdy_o, bus0.l1d_req_vld_o, bus0.l1d_req_o,
                  bus0.lsu_resp_vld_o, bus0.lsu_resp_o, outs0, uf0);
        model_cmp(1, bus1.lsu_req_rdy_o, bus1.l1d_req_vld_o, bus1.l1d_req_o,
                  bus1.lsu_resp_vld_o, bus1.lsu_resp_o, outs1, uf1);
    end

    function automatic lsu_req_t mk_req(input int id, input int rob, input logic [5:0] t,
                                        input logic [55:0] pa, input int rd);
        lsu_req_t r;
        r              = '0;
        r.lsu_id       = 4'(id);
        r.rob_id       = 7'(rob);
        r.req_type     = t;
        r.paddr        = pa;
        r.ld_rd_idx    = 7'(rd);
        r.st_dat       = {8'h5a, pa};
        r.is_cacheable = 1'b1;
        return r;
    endfunction

    function automatic lsu_resp_t mk_resp(input int id, input int rob, input logic [63:0] d,
                                          input int rd, input logic e);
        lsu_resp_t p;
        p           = '0;
        p.lsu_id    = 4'(id);
        p.rob_id    = 7'(rob);
        p.ld_data   = d;
        p.ld_rd_idx = 7'(rd);
        p.err       = e;
        return p;
    endfunction

    task automatic drive(input logic rv, input lsu_req_t r, input logic lr,
                         input logic pv, input lsu_resp_t p);
        @(negedge clk);
        req_vld  = rv;
        req      = r;
        l1d_rdy  = lr;
        resp_vld = pv;
        resp     = p;
    endtask

    task automatic idle(input logic lr);
        drive(1'b0, '0, lr, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(1'b0);
        #4;
        chk("rst_outs0", 256'(outs0), 256'(0));
        chk("rst_outs1", 256'(outs1), 256'(0));
        chk("rst_uf0", 256'(uf0), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(1'b0);
        idle(1'b0);
        #4;
        chk("init_rdy", 256'(bus0.lsu_req_rdy_o), 256'(1'b1));
        chk("init_vld", 256'(bus0.l1d_req_vld_o), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full with L1D stalled; a ninth push is refused.
        for (int i = 0; i < 8; i++) drive(1'b1, mk_req(i, 16 + i, 6'd0, 56'(i * 64), i), 1'b0, 1'b0, '0);
        drive(1'b1, mk_req(9, 25, 6'd0, 56'h9999, 9), 1'b0, 1'b0, '0);
        #4;
        chk("t1_full_rdy0", 256'(bus0.lsu_req_rdy_o), 256'(1'b0));
        chk("t1_full_rdy1", 256'(bus1.lsu_req_rdy_o), 256'(1'b0));
        idle(1'b1);
        #4;
        chk("t1_first_id", 256'(bus0.l1d_req_o.lsu_id), 256'(0));
        repeat (7) idle(1'b1);
        idle(1'b1);
        #4;
        chk("t1_outs8", 256'(outs0), 256'(8));
        chk("t1_drained", 256'(bus0.l1d_req_vld_o), 256'(1'b0));
        chk("t2_cap_outs", 256'(outs1), 256'(2));
        chk("t2_cap_vld", 256'(bus1.l1d_req_vld_o), 256'(1'b0));

        // One response frees a slot on the capped instance; the third load issues next cycle.
        drive(1'b0, '0, 1'b1, 1'b1, mk_resp(0, 16, 64'h1111, 0, 1'b0));
        #4;
        chk("t2_still_capped", 256'(bus1.l1d_req_vld_o), 256'(1'b0));
        chk("t2_resp_fwd", 256'(bus1.lsu_resp_vld_o), 256'(1'b1));
        idle(1'b1);
        #4;
        chk("t2_third_vld", 256'(bus1.l1d_req_vld_o), 256'(1'b1));
        chk("t2_third_id", 256'(bus1.l1d_req_o.lsu_id), 256'(2));
        chk("t2_outs1", 256'(outs1), 256'(1));

        // Reset with work queued and in flight, then a stray response counts as underflow.
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b1, mk_resp(3, 3, 64'hbeef, 1, 1'b1));
        #4;
        chk("t5_fwd_vld", 256'(bus0.lsu_resp_vld_o), 256'(1'b1));
        chk("t5_fwd_data", 256'(bus0.lsu_resp_o.ld_data), 256'(64'hbeef));
        idle(1'b0);
        #4;
        chk("t5_uf_set", 256'(uf0), 256'(1'b1));
        chk("t5_outs_sat", 256'(outs0), 256'(0));
        idle(1'b0);
        idle(1'b0);
        #4;
        chk("t5_uf_sticky", 256'(uf0), 256'(1'b1));
        do_reset();

        // Fence waits behind an issued load, then completes locally.
        drive(1'b1, mk_req(1, 10, 6'd0, 56'h2000, 5), 1'b1, 1'b0, '0);
        drive(1'b1, mk_req(2, 11, LSU_FENCE, 56'h0, 3), 1'b1, 1'b0, '0);
        idle(1'b1);
        #4;
        chk("t3_fence_held", 256'(bus0.l1d_req_vld_o), 256'(1'b0));
        chk("t3_outs1", 256'(outs0), 256'(1));
        chk("t3_no_resp", 256'(bus0.lsu_resp_vld_o), 256'(1'b0));
        idle(1'b1);
        drive(1'b0, '0, 1'b1, 1'b1, mk_resp(1, 10, 64'hdead_beef, 5, 1'b0));
        #4;
        chk("t3_a_data", 256'(bus0.lsu_resp_o.ld_data), 256'(64'hdead_beef));
        chk("t3_a_err", 256'(bus0.lsu_resp_o.err), 256'(1'b0));
        idle(1'b1);
        #4;
        chk("t3_f_vld", 256'(bus0.lsu_resp_vld_o), 256'(1'b1));
        chk("t3_f_id", 256'(bus0.lsu_resp_o.lsu_id), 256'(2));
        chk("t3_f_type", 256'(bus0.lsu_resp_o.req_type), 256'(6'd38));
        chk("t3_f_data", 256'(bus0.lsu_resp_o.ld_data), 256'(0));
        idle(1'b1);
        #4;
        chk("t3_f_popped", 256'(bus0.lsu_resp_vld_o), 256'(1'b0));

        // Fence eligible in the same cycle an L1D response arrives: L1D first, fence next.
        drive(1'b1, mk_req(4, 20, 6'd0, 56'h3000, 6), 1'b1, 1'b0, '0);
        drive(1'b1, mk_req(5, 21, LSU_FENCE, 56'h0, 7), 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b1, mk_resp(4, 20, 64'h4444, 6, 1'b0));
        drive(1'b0, '0, 1'b1, 1'b1, mk_resp(9, 30, 64'h77, 8, 1'b0));
        #4;
        chk("t4_l1d_first", 256'(bus0.lsu_resp_o.lsu_id), 256'(9));
        idle(1'b1);
        #4;
        chk("t4_fence_vld", 256'(bus0.lsu_resp_vld_o), 256'(1'b1));
        chk("t4_fence_id", 256'(bus0.lsu_resp_o.lsu_id), 256'(5));
        idle(1'b1);
        #4;
        chk("t4_done", 256'(bus0.lsu_resp_vld_o), 256'(1'b0));

        // Enqueue-to-issue latency from an empty queue.
        do_reset();
        drive(1'b1, mk_req(6, 40, 6'd0, 56'h1000, 9), 1'b1, 1'b0, '0);
        #4;
`ifdef RUBY_LSU_REQ_QUEUE_BYPASS_EN
        chk("t6_same_vld", 256'(bus0.l1d_req_vld_o), 256'(1'b1));
        chk("t6_same_paddr", 256'(bus0.l1d_req_o.paddr), 256'(56'h1000));
`else
        chk("t6_same_vld", 256'(bus0.l1d_req_vld_o), 256'(1'b0));
`endif
        idle(1'b1);
        #4;
`ifdef RUBY_LSU_REQ_QUEUE_BYPASS_EN
        chk("t6_next_vld", 256'(bus0.l1d_req_vld_o), 256'(1'b0));
`else
        chk("t6_next_vld", 256'(bus0.l1d_req_vld_o), 256'(1'b1));
        chk("t6_next_paddr", 256'(bus0.l1d_req_o.paddr), 256'(56'h1000));
`endif
        idle(1'b0);
        idle(1'b0);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
